// File: rtl/regfile_ctrl.sv
// regfile_ctrl: arbitrates the register-file write port between writeback and a debug port.
// Optional reset-time clear of x1..x31 is compiled in with REGFILE_CTRL_CLEAR_EN.
module regfile_ctrl #(
  parameter int DBG_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_wd,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [4:0]  rf_ra,
  input  logic [31:0] rf_rdata,
  output logic        stall
);
  localparam logic [1:0] IDLE = 2'd0, ACK = 2'd1, CLEAR = 2'd2;
  localparam int SW = $clog2(DBG_TIMEOUT + 2);
  logic [1:0] state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0] rdata_q, rdata_d;
  logic wr_pend, rd_grant, wr_grant, timeout;
  logic clr, clr_we, clr_done;
  logic [4:0] clr_a3;
`ifdef REGFILE_CTRL_CLEAR_EN
  localparam logic [1:0] RST_STATE = CLEAR;
  logic go_q;
  logic [4:0] clr_cnt_q;
  assign clr = state_q == CLEAR;
  // go_q holds off the first clear write until the first clock after reset release
  assign clr_we = go_q;
  assign clr_a3 = clr_cnt_q;
  assign clr_done = go_q && clr_cnt_q == 5'd31;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      go_q <= 1'b0;
      clr_cnt_q <= 5'd1;
    end else begin
      go_q <= 1'b1;
      clr_cnt_q <= (clr && go_q) ? clr_cnt_q + 5'd1 : clr_cnt_q;
    end
`else
  localparam logic [1:0] RST_STATE = IDLE;
  assign clr = 1'b0;
  assign clr_we = 1'b0;
  assign clr_a3 = 5'd0;
  assign clr_done = 1'b0;
`endif
  assign wr_pend = state_q == IDLE && dbg_req && dbg_we;
  assign rd_grant = state_q == IDLE && dbg_req && !dbg_we;
  assign timeout = wr_pend && starve_q == SW'(DBG_TIMEOUT);
  assign wr_grant = wr_pend && (!wb_we || timeout);
  assign stall = clr || timeout;
  assign rf_we = clr ? clr_we : wr_grant ? |dbg_addr : wb_we && !timeout;
  assign rf_a3 = clr ? clr_a3 : wr_grant ? dbg_addr : wb_a3;
  assign rf_wd = clr ? 32'd0 : wr_grant ? dbg_wdata : wb_wd;
  assign rf_ra = dbg_addr;
  assign dbg_ack = state_q == ACK;
  assign dbg_rdata = rdata_q;
  assign state_d = clr ? (clr_done ? IDLE : CLEAR) : (rd_grant || wr_grant) ? ACK : IDLE;
  assign starve_d = (wr_pend && !wr_grant) ? starve_q + SW'(1) : '0;
  // a same-cycle writeback to the read address wins over the stale register-file value
  assign rdata_d = !rd_grant ? rdata_q : dbg_addr == 5'd0 ? 32'd0 :
                   (wb_we && wb_a3 == dbg_addr) ? wb_wd : rf_rdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= RST_STATE;
      starve_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      rdata_q <= rdata_d;
    end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed and randomized checks of regfile_ctrl against a transaction-level model.
module tb_regfile_ctrl;
  localparam int TO = 15;
`ifdef REGFILE_CTRL_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n, wb_we, dbg_req, dbg_we, dbg_ack, rf_we, stall;
  logic [4:0] wb_a3, dbg_addr, rf_a3, rf_ra;
  logic [31:0] wb_wd, dbg_wdata, dbg_rdata, rf_wd, rf_rdata;
  logic [31:0] rf_mem [32];
  logic [31:0] mem_m [32];
  int n_chk = 0, n_fail = 0;
  int waitc = 0, n;
  logic pend = 0, in_ack = 0, p_we = 0, wb_hold = 0, seen_stall = 0;
  logic [31:0] exp_rd = 0, last_rd = 0;

  regfile_ctrl #(.DBG_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .rf_ra(rf_ra), .rf_rdata(rf_rdata), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rf_we) rf_mem[rf_a3] <= rf_wd;
  assign rf_rdata = (rf_ra == 5'd0) ? 32'd0 : rf_mem[rf_ra];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already applied just after a falling edge.
  task automatic cyc();
    logic g, st, we_e, done;
    logic [4:0] a_e;
    logic [31:0] d_e;
    #1;
    g = 0;
    st = 0;
    if (pend && !in_ack) begin
      if (!dbg_we) g = 1;
      else begin
        st = (waitc == TO);
        g = !wb_we || st;
      end
    end
    we_e = (g && dbg_we) ? (dbg_addr != 0) : (wb_we && !st);
    a_e = (g && dbg_we) ? dbg_addr : wb_a3;
    d_e = (g && dbg_we) ? dbg_wdata : wb_wd;
    seen_stall = stall;
    chk("stall", stall, st);
    chk("dbg_ack", dbg_ack, in_ack);
    chk("rf_we", rf_we, we_e);
    if (we_e) begin
      chk("rf_a3", rf_a3, a_e);
      chk("rf_wd", rf_wd, d_e);
    end
    if (in_ack && !p_we) begin
      chk("dbg_rdata", dbg_rdata, exp_rd);
      last_rd = dbg_rdata;
    end
    if (g && !dbg_we)
      exp_rd = (dbg_addr == 0) ? 32'd0 : (wb_we && wb_a3 == dbg_addr) ? wb_wd : mem_m[dbg_addr];
    if (we_e && a_e != 0) mem_m[a_e] = d_e;
    wb_hold = st;
    waitc = (pend && !in_ack && dbg_we && !g) ? waitc + 1 : 0;
    done = in_ack;
    in_ack = g;
    @(posedge clk);
    @(negedge clk);
    if (done) begin
      pend = 0;
      dbg_req = 0;
    end
  endtask

  task automatic start(input logic we, input logic [4:0] a, input logic [31:0] d);
    pend = 1;
    p_we = we;
    dbg_req = 1;
    dbg_we = we;
    dbg_addr = a;
    dbg_wdata = d;
  endtask

  task automatic dbg(input logic we, input logic [4:0] a, input logic [31:0] d);
    start(we, a, d);
    for (int i = 0; i < 40 && pend; i++) cyc();
    if (pend) begin
      chk("dbg_done", pend, 1'b0);
      pend = 0;
      dbg_req = 0;
      in_ack = 0;
    end
  endtask

  // Reset, then (with clearing) walk the clear sequence; abort_at>0 re-asserts reset at that count.
  task automatic do_reset(input int abort_at);
    reset_n = 0;
    dbg_req = 0;
    wb_we = 0;
    pend = 0;
    in_ack = 0;
    waitc = 0;
    wb_hold = 0;
    #1;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_ack", dbg_ack, 1'b0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_stall", stall, CLR);
    @(negedge clk);
    reset_n = 1;
`ifdef REGFILE_CTRL_CLEAR_EN
    #1;
    chk("pre_rf_we", rf_we, 1'b0);
    chk("pre_stall", stall, 1'b1);
    @(negedge clk);
    for (int i = 1; i <= 31; i++) begin
      wb_we = 1;
      wb_a3 = 5'(31 - i);
      wb_wd = 32'hFFFF_FFFF;
      dbg_req = (i < 31);
      dbg_we = 0;
      dbg_addr = 5'd4;
      #1;
      chk("clr_we", rf_we, 1'b1);
      chk("clr_a3", rf_a3, 5'(i));
      chk("clr_wd", rf_wd, 32'd0);
      chk("clr_stall", stall, 1'b1);
      chk("clr_ack", dbg_ack, 1'b0);
      if (i == abort_at) begin
        reset_n = 0;
        #1;
        chk("abort_rf_we", rf_we, 1'b0);
        chk("abort_stall", stall, 1'b1);
        return;
      end
      @(negedge clk);
    end
    wb_we = 0;
    dbg_req = 0;
    for (int i = 0; i < 32; i++) mem_m[i] = 0;
`endif
  endtask

  initial begin
    reset_n = 0;
    wb_we = 0; wb_a3 = 0; wb_wd = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      mem_m[i] = (i == 0) ? 32'd0 : rf_mem[i];
    end
    @(negedge clk);
    if (CLR) do_reset(10);
    do_reset(0);
    wb_we = 1; wb_a3 = 5; wb_wd = 32'hDEAD_BEEF;
    cyc();
    wb_a3 = 7; wb_wd = 32'h0000_1234;
    dbg(0, 7, 0);
    chk("rd_x7_bypass", last_rd, 32'h0000_1234);
    wb_a3 = 0; wb_wd = 32'hFFFF_FFFF;
    dbg(0, 0, 0);
    chk("rd_x0", last_rd, 32'd0);
    wb_we = 1; wb_a3 = 9; wb_wd = 32'h0000_0099;
    start(1, 3, 32'hA5A5_A5A5);
    n = 0;
    seen_stall = 0;
    while (!seen_stall && n < 40) begin
      cyc();
      if (!seen_stall) n++;
    end
    chk("starve_wait", n, 15);
    cyc();
    pend = 0; dbg_req = 0; in_ack = 0; waitc = 0;
    wb_we = 0;
    dbg(0, 3, 0);
    chk("rd_x3", last_rd, 32'hA5A5_A5A5);
    dbg(0, 9, 0);
    chk("rd_x9", last_rd, 32'h0000_0099);
    dbg(1, 0, 32'hFFFF_FFFF);
    dbg(0, 0, 0);
    chk("rd_x0_after_wr", last_rd, 32'd0);
    start(0, 4, 0);
    cyc();
    do_reset(0);
    cyc();
    for (int c = 0; c < 800; c++) begin
      if (!wb_hold) begin
        wb_we = $urandom_range(0, 9) < (((c / 100) % 2) ? 9 : 4);
        wb_a3 = 5'($urandom_range(0, 31));
        wb_wd = $urandom;
      end
      if (!pend && !in_ack && $urandom_range(0, 3) == 0)
        start(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      cyc();
    end
    for (int i = 0; i < 40 && (pend || in_ack); i++) cyc();
    wb_we = 0;
    for (int a = 0; a < 32; a++) begin
      dbg(0, 5'(a), 0);
      chk("readback", last_rd, mem_m[a]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
